// File: rtl/intr_priority_ctrl_pkg.sv
// Shared types and helpers for the interrupt priority controller.
// Package name: intr_ctrl_pkg.
package intr_ctrl_pkg;

    // Arbitration FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam int N_SRC_DEF = 6;
    localparam int VEC_W_DEF = 3;
    localparam int VEC_NONE  = 0;

    // Map a one-hot vector (bit k set) to line id k+1; all-zero maps to 0.
    function automatic logic [3:0] onehot_to_id(input logic [7:0] oh);
        logic [3:0] id;
        id = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (oh[k]) begin
                id = 4'(k + 1);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/intr_priority_ctrl_if.sv
// Interface bundling the interrupt lines, core handshake and status outputs.
// The slave modport is the controller's view; the master modport is the
// environment (generator + core) view.
interface intr_priority_ctrl_if
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int VEC_W = VEC_W_DEF
);
    logic [N_SRC-1:0] INTR;
    logic             GIE;
    logic             MASK_WE;
    logic [N_SRC-1:0] MASK_WD;
    logic             ACK;
    logic             ERET;
    logic             IRQ;
    logic [VEC_W-1:0] VEC;
    logic [N_SRC-1:0] CLR;
    logic [N_SRC-1:0] MASK;
    logic [N_SRC-1:0] ISR;

    modport slave (
        input  INTR, GIE, MASK_WE, MASK_WD, ACK, ERET,
        output IRQ, VEC, CLR, MASK, ISR
    );

    modport master (
        output INTR, GIE, MASK_WE, MASK_WD, ACK, ERET,
        input  IRQ, VEC, CLR, MASK, ISR
    );

endinterface

// File: rtl/intr_priority_ctrl_prio_enc.sv
// Combinational lowest-index priority encoder: returns {valid, id} where
// id is the 1-based index of the lowest set bit (line 1 = bit 0).
module intr_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter int N = N_SRC_DEF,
    parameter int W = VEC_W_DEF
)(
    input  logic [N-1:0] i_vec,
    output logic         o_valid,
    output logic [W-1:0] o_id
);
    logic [N-1:0] w_low;
    logic [7:0]   w_oh;

    // Isolate the lowest set bit, then convert it to a line id
    always_comb begin
        w_low   = i_vec & (~i_vec + N'(1));
        w_oh    = 8'(w_low);
        o_valid = |i_vec;
        o_id    = W'(onehot_to_id(w_oh));
    end

endmodule

// File: rtl/intr_priority_ctrl.sv
// Interrupt priority controller: masks and arbitrates latched interrupt
// lines, presents IRQ/VEC to the core, tracks in-service lines and issues
// CLR pulses on acknowledge.
// Optional macro INTR_NEST_EN: when defined, a strictly higher-priority
// line may preempt lines already in service; when undefined, a new request
// is only raised while no line is in service.
module intr_priority_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int VEC_W = VEC_W_DEF
)(
    input  logic                CLK,
    input  logic                RST,
    intr_priority_ctrl_if.slave bus
);
    localparam logic [VEC_W:0] CEIL_NONE = (VEC_W + 1)'(N_SRC + 1);

    state_t           r_state;
    logic             r_irq;
    logic [VEC_W-1:0] r_vec;
    logic [N_SRC-1:0] r_clr;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_isr;

    logic [N_SRC-1:0] w_pending;
    logic             w_cand_valid;
    logic [VEC_W-1:0] w_cand_id;
    logic             w_ceil_valid;
    logic [VEC_W-1:0] w_ceil_id;
    logic [VEC_W:0]   w_ceil;
    logic             w_eligible;
    logic [N_SRC-1:0] w_id_oh;
    logic             w_withdraw;
    logic             w_ack_take;
    logic [N_SRC-1:0] w_isr_low;
    logic [N_SRC-1:0] w_isr_next;

    // Lines already in service are excluded so a late INTR drop after CLR
    // cannot re-trigger the same line.
    assign w_pending = bus.INTR & r_mask & ~r_isr;

    intr_prio_enc #(.N(N_SRC), .W(VEC_W)) u_enc_cand (
        .i_vec   (w_pending),
        .o_valid (w_cand_valid),
        .o_id    (w_cand_id)
    );

    intr_prio_enc #(.N(N_SRC), .W(VEC_W)) u_enc_ceil (
        .i_vec   (r_isr),
        .o_valid (w_ceil_valid),
        .o_id    (w_ceil_id)
    );

    // Eligibility: candidate must beat the highest-priority line in service
    always_comb begin
        if (w_ceil_valid) begin
            w_ceil = {1'b0, w_ceil_id};
        end else begin
            w_ceil = CEIL_NONE;
        end
`ifdef INTR_NEST_EN
        w_eligible = bus.GIE & w_cand_valid & ({1'b0, w_cand_id} < w_ceil);
`else
        w_eligible = bus.GIE & w_cand_valid & ({1'b0, w_cand_id} < w_ceil)
                   & (r_isr == {N_SRC{1'b0}});
`endif
    end

    // Decode the presented line and evaluate ACK / withdraw conditions
    always_comb begin
        if (r_vec != VEC_W'(VEC_NONE)) begin
            w_id_oh = N_SRC'(1) << (r_vec - VEC_W'(1));
        end else begin
            w_id_oh = {N_SRC{1'b0}};
        end
        w_ack_take = (r_state == REQ) & bus.ACK;
        w_withdraw = ~bus.GIE | ~(|(r_mask & w_id_oh)) | ~(|(bus.INTR & w_id_oh));
    end

    // Next in-service value: ERET clears the lowest set bit of the old ISR,
    // ACK sets the acknowledged line; both may apply in one cycle.
    always_comb begin
        w_isr_low  = r_isr & (~r_isr + N_SRC'(1));
        w_isr_next = r_isr;
        if (bus.ERET) begin
            w_isr_next = w_isr_next & ~w_isr_low;
        end else begin
            w_isr_next = w_isr_next;
        end
        if (w_ack_take) begin
            w_isr_next = w_isr_next | w_id_oh;
        end else begin
            w_isr_next = w_isr_next;
        end
    end

    // Request FSM with registered IRQ, VEC and CLR outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_vec   <= VEC_W'(VEC_NONE);
            r_clr   <= {N_SRC{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_clr <= {N_SRC{1'b0}};
                    if (w_eligible) begin
                        r_state <= REQ;
                        r_irq   <= 1'b1;
                        r_vec   <= w_cand_id;
                    end else begin
                        r_state <= IDLE;
                        r_irq   <= 1'b0;
                        r_vec   <= VEC_W'(VEC_NONE);
                    end
                end
                REQ: begin
                    if (bus.ACK) begin
                        r_state <= IDLE;
                        r_irq   <= 1'b0;
                        r_vec   <= VEC_W'(VEC_NONE);
                        r_clr   <= w_id_oh;
                    end else if (w_withdraw) begin
                        r_state <= IDLE;
                        r_irq   <= 1'b0;
                        r_vec   <= VEC_W'(VEC_NONE);
                        r_clr   <= {N_SRC{1'b0}};
                    end else begin
                        r_state <= REQ;
                        r_clr   <= {N_SRC{1'b0}};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_irq   <= 1'b0;
                    r_vec   <= VEC_W'(VEC_NONE);
                    r_clr   <= {N_SRC{1'b0}};
                end
            endcase
        end
    end

    // Mask register; reset leaves every line masked
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mask <= {N_SRC{1'b0}};
        end else if (bus.MASK_WE) begin
            r_mask <= bus.MASK_WD;
        end else begin
            r_mask <= r_mask;
        end
    end

    // In-service register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_isr <= {N_SRC{1'b0}};
        end else begin
            r_isr <= w_isr_next;
        end
    end

    assign bus.IRQ  = r_irq;
    assign bus.VEC  = r_vec;
    assign bus.CLR  = r_clr;
    assign bus.MASK = r_mask;
    assign bus.ISR  = r_isr;

endmodule

// File: tb/tb_intr_priority_ctrl.sv
// Directed self-checking bench for intr_priority_ctrl (N_SRC=6, VEC_W=3).
// Handles both builds of the INTR_NEST_EN option.
module tb_intr_priority_ctrl;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    intr_priority_ctrl_if #(.N_SRC(6), .VEC_W(3)) bus ();

    intr_priority_ctrl #(.N_SRC(6), .VEC_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic irq, input logic [2:0] vec,
                             input logic [5:0] clr, input logic [5:0] isr);
        check({tag, ".irq"}, 8'(bus.IRQ), 8'(irq));
        check({tag, ".vec"}, 8'(bus.VEC), 8'(vec));
        check({tag, ".clr"}, 8'(bus.CLR), 8'(clr));
        check({tag, ".isr"}, 8'(bus.ISR), 8'(isr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        RST         = 1'b1;
        bus.INTR    = 6'b000000;
        bus.GIE     = 1'b0;
        bus.MASK_WE = 1'b0;
        bus.MASK_WD = 6'b000000;
        bus.ACK     = 1'b0;
        bus.ERET    = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 3'd0, 6'b000000, 6'b000000);
        check("reset.mask", 8'(bus.MASK), 8'h00);
        RST = 1'b0;

        // enable all lines
        bus.MASK_WE = 1'b1; bus.MASK_WD = 6'b111111;
        tick();
        check("mask_write", 8'(bus.MASK), 8'h3f);
        bus.MASK_WE = 1'b0;

        // basic request on line 3
        bus.GIE = 1'b1; bus.INTR = 6'b000100;
        tick();
        check_out("basic_req", 1'b1, 3'd3, 6'b000000, 6'b000000);
        bus.ACK = 1'b1;
        tick();
        check_out("basic_ack", 1'b0, 3'd0, 6'b000100, 6'b000100);
        bus.ACK = 1'b0;                          // INTR still high this cycle
        tick();
        check_out("no_rereq", 1'b0, 3'd0, 6'b000000, 6'b000100);
        bus.INTR = 6'b000000; bus.ERET = 1'b1;
        tick();
        check_out("basic_eret", 1'b0, 3'd0, 6'b000000, 6'b000000);
        bus.ERET = 1'b0;

        // priority: lines 4 and 6 together
        bus.INTR = 6'b101000;
        tick();
        check_out("prio_req", 1'b1, 3'd4, 6'b000000, 6'b000000);
        bus.ACK = 1'b1;
        tick();
        check_out("prio_ack", 1'b0, 3'd0, 6'b001000, 6'b001000);
        bus.ACK = 1'b0; bus.INTR = 6'b100000;
        tick();
        tick();
        check_out("prio_block6", 1'b0, 3'd0, 6'b000000, 6'b001000);
        bus.ERET = 1'b1;
        tick();
        check_out("prio_eret", 1'b0, 3'd0, 6'b000000, 6'b000000);
        bus.ERET = 1'b0;
        tick();
        check_out("prio_req6", 1'b1, 3'd6, 6'b000000, 6'b000000);
        bus.ACK = 1'b1;
        tick();
        check_out("prio_ack6", 1'b0, 3'd0, 6'b100000, 6'b100000);
        bus.ACK = 1'b0; bus.INTR = 6'b000000; bus.ERET = 1'b1;
        tick();
        check("prio_eret6", 8'(bus.ISR), 8'h00);
        bus.ERET = 1'b0;

        // nesting: line 5 in service, line 2 arrives
        bus.INTR = 6'b010000;
        tick();
        check_out("nest_req5", 1'b1, 3'd5, 6'b000000, 6'b000000);
        bus.ACK = 1'b1;
        tick();
        check("nest_isr5", 8'(bus.ISR), 8'h10);
        bus.ACK = 1'b0; bus.INTR = 6'b000010;
        tick();
`ifdef INTR_NEST_EN
        check_out("nest_req2", 1'b1, 3'd2, 6'b000000, 6'b010000);
        bus.ACK = 1'b1;
        tick();
        check_out("nest_ack2", 1'b0, 3'd0, 6'b000010, 6'b010010);
        bus.ACK = 1'b0; bus.INTR = 6'b000000; bus.ERET = 1'b1;
        tick();
        check("nest_eret1", 8'(bus.ISR), 8'h10);
        tick();
        check("nest_eret2", 8'(bus.ISR), 8'h00);
        bus.ERET = 1'b0;
`else
        check_out("nonest_block", 1'b0, 3'd0, 6'b000000, 6'b010000);
        bus.ERET = 1'b1;
        tick();
        check_out("nonest_eret", 1'b0, 3'd0, 6'b000000, 6'b000000);
        bus.ERET = 1'b0;
        tick();
        check_out("nonest_req2", 1'b1, 3'd2, 6'b000000, 6'b000000);
        bus.ACK = 1'b1;
        tick();
        check("nonest_isr2", 8'(bus.ISR), 8'h02);
        bus.ACK = 1'b0; bus.INTR = 6'b000000; bus.ERET = 1'b1;
        tick();
        check("nonest_eret2", 8'(bus.ISR), 8'h00);
        bus.ERET = 1'b0;
`endif

        // withdraw by masking line 4
        bus.INTR = 6'b001000;
        tick();
        check_out("wd_req", 1'b1, 3'd4, 6'b000000, 6'b000000);
        bus.MASK_WE = 1'b1; bus.MASK_WD = 6'b110111;
        tick();
        check("wd_mask", 8'(bus.MASK), 8'h37);
        bus.MASK_WE = 1'b0;
        tick();
        check_out("wd_mask_drop", 1'b0, 3'd0, 6'b000000, 6'b000000);
        bus.MASK_WE = 1'b1; bus.MASK_WD = 6'b111111;
        tick();
        check("wd_unmask_irq", 8'(bus.IRQ), 8'h00);
        bus.MASK_WE = 1'b0;
        tick();
        check_out("wd_rereq", 1'b1, 3'd4, 6'b000000, 6'b000000);
        // withdraw by GIE
        bus.GIE = 1'b0;
        tick();
        check_out("wd_gie_drop", 1'b0, 3'd0, 6'b000000, 6'b000000);
        bus.GIE = 1'b1;
        tick();
        check_out("wd_gie_rereq", 1'b1, 3'd4, 6'b000000, 6'b000000);
        // ACK wins over a simultaneous withdraw condition
        bus.GIE = 1'b0; bus.ACK = 1'b1;
        tick();
        check_out("ack_wins", 1'b0, 3'd0, 6'b001000, 6'b001000);
        bus.ACK = 1'b0; bus.GIE = 1'b1; bus.INTR = 6'b000000; bus.ERET = 1'b1;
        tick();
        check("ack_wins_eret", 8'(bus.ISR), 8'h00);
        bus.ERET = 1'b0;

        // ACK and ERET in the same cycle
`ifdef INTR_NEST_EN
        bus.INTR = 6'b000010;
        tick();
        bus.ACK = 1'b1;
        tick();
        check("ae_isr2", 8'(bus.ISR), 8'h02);
        bus.ACK = 1'b0; bus.INTR = 6'b000001;
        tick();
        check_out("ae_req1", 1'b1, 3'd1, 6'b000000, 6'b000010);
`else
        bus.INTR = 6'b000001;
        tick();
        check_out("ae_req1", 1'b1, 3'd1, 6'b000000, 6'b000000);
`endif
        bus.ACK = 1'b1; bus.ERET = 1'b1;
        tick();
        check_out("ack_eret", 1'b0, 3'd0, 6'b000001, 6'b000001);
        bus.ACK = 1'b0; bus.INTR = 6'b000000;
        tick();
        check("ae_cleanup", 8'(bus.ISR), 8'h00);
        bus.ERET = 1'b0;

        // ACK in IDLE is ignored
        bus.ACK = 1'b1;
        tick();
        check_out("ack_idle", 1'b0, 3'd0, 6'b000000, 6'b000000);
        bus.ACK = 1'b0;

        // asynchronous reset during REQ
        bus.INTR = 6'b000100;
        tick();
        check_out("rst_pre", 1'b1, 3'd3, 6'b000000, 6'b000000);
        #2;
        RST = 1'b1;
        #1;
        check_out("rst_async", 1'b0, 3'd0, 6'b000000, 6'b000000);
        check("rst_async.mask", 8'(bus.MASK), 8'h00);
        tick();
        RST = 1'b0;
        tick();
        check_out("rst_after", 1'b0, 3'd0, 6'b000000, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
